// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, FSM states,
// mux-select constants and the raw control word produced by the state decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;

  // mem_gate marks enables that only fire on the cycle memory completes
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       mem_gate;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Purely combinational Moore decode of the FSM state into the raw control word.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb  = ALUSRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsrc    = PCSRC_ALU;
        ctrl.irwrite  = 1'b1;
        ctrl.pcwrite  = 1'b1;
        ctrl.mem_gate = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = ALUSRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_RT;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main-control FSM: sequencing, mem_ready handshake gating
// and a wrapping retired-instruction counter.
module mc_maindec
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              op,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pcen,
  output logic                    irwrite,
  output logic                    memwrite,
  output logic                    regwrite,
  output logic                    iord,
  output logic                    memtoreg,
  output logic                    regdst,
  output logic                    alusrca,
  output logic [1:0]              alusrcb,
  output logic [1:0]              pcsrc,
  output logic [1:0]              aluop,
  output logic                    illegal_op,
  output logic [3:0]              state,
  output logic [RETIRE_CNT_W-1:0] instret
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   gate;
  logic   retire;

  mc_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret <= instret + RETIRE_CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    illegal_op = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_RESET:   state_d = S_FETCH;
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:   state_d = S_FETCH;
    endcase
  end

  assign gate     = ctrl.mem_gate ? mem_ready : 1'b1;
  assign pcen     = (ctrl.pcwrite & gate) | (ctrl.branch & zero);
  assign irwrite  = ctrl.irwrite & gate;
  assign memwrite = ctrl.memwrite;
  assign regwrite = ctrl.regwrite;
  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: an instruction-level model queues the expected
// per-cycle outputs, and a negedge monitor compares them against the DUT.
module tb_mc_maindec;

  localparam int unsigned CW = 4;
  localparam logic [5:0] T_RTYPE = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

  logic          clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0]    op = '0;
  logic          pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0]    alusrcb, pcsrc, aluop;
  logic          illegal_op;
  logic [3:0]    state;
  logic [CW-1:0] instret;

  mc_maindec #(.RETIRE_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [14:0]   ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  int unsigned model_cnt = 0;

  function automatic bit legal(input logic [5:0] o);
    return (o == T_RTYPE) || (o == T_LW) || (o == T_SW) ||
           (o == T_BEQ) || (o == T_ADDI) || (o == T_J);
  endfunction

  // {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,aluop,illegal_op}
  function automatic logic [14:0] ctl_for(input int s, input logic [5:0] o,
                                          input logic z, input logic r);
    logic pe, irw, mw, rw, iod, m2r, rd, asa, ill;
    logic [1:0] asb, pcs, aop;
    {pe, irw, mw, rw, iod, m2r, rd, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (s)
      1:  begin asb = 2'b01; irw = r; pe = r; end
      2:  begin asb = 2'b11; ill = !legal(o); end
      3:  begin asa = 1'b1; asb = 2'b10; end
      4:  iod = 1'b1;
      5:  begin m2r = 1'b1; rw = 1'b1; end
      6:  begin iod = 1'b1; mw = 1'b1; end
      7:  begin asa = 1'b1; aop = 2'b10; end
      8:  begin rd = 1'b1; rw = 1'b1; end
      9:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pe = z; end
      10: begin asa = 1'b1; asb = 2'b10; end
      11: rw = 1'b1;
      12: begin pcs = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {pe, irw, mw, rw, iod, m2r, rd, asa, asb, pcs, aop, ill};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e   = q.pop_front();
      act = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
             alusrcb, pcsrc, aluop, illegal_op};
      checks += 3;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state t=%0t got %0d want %0d", $time, state, e.st);
      end
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctrl t=%0t state=%0d got %b want %b", $time, e.st, act, e.ctl);
      end
      if (instret !== e.cnt) begin
        errors++;
        $display("FAIL instret t=%0t got %0d want %0d", $time, instret, e.cnt);
      end
    end
  end

  // One cycle of expectation; entered and left at posedge+1.
  task automatic step(input int s, input logic r);
    mem_ready = r;
    q.push_back({4'(s), ctl_for(s, op, zero, r), CW'(model_cnt)});
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  task automatic run_instr(input logic [5:0] o, input logic z, input int fw, input int mw);
    op = o;
    zero = z;
    repeat (fw) step(1, 1'b0);
    step(1, 1'b1);
    step(2, 1'($urandom));
    if (legal(o)) begin
      case (o)
        T_LW: begin
          step(3, 1'($urandom));
          repeat (mw) step(4, 1'b0);
          step(4, 1'b1);
          step(5, 1'($urandom));
        end
        T_SW: begin
          step(3, 1'($urandom));
          repeat (mw) step(6, 1'b0);
          step(6, 1'b1);
        end
        T_RTYPE: begin step(7, 1'($urandom)); step(8, 1'($urandom)); end
        T_BEQ:   step(9, 1'($urandom));
        T_ADDI:  begin step(10, 1'($urandom)); step(11, 1'($urandom)); end
        default: step(12, 1'($urandom));
      endcase
      retire();
    end
  endtask

  function automatic logic [5:0] rand_op(input bit allow_illegal);
    logic [5:0] ops [6];
    logic [5:0] o;
    ops = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_ADDI, T_J};
    if (allow_illegal && ($urandom_range(0, 6) == 0)) begin
      o = 6'($urandom);
      for (int i = 0; i < 8 && legal(o); i++) o = 6'($urandom);
      if (legal(o)) o = 6'b111111;
      return o;
    end
    return ops[$urandom_range(0, 5)];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    model_cnt = 0;
    step(0, 1'b1);
    step(0, 1'b1);
    step(0, 1'b1);
    rst_n = 1'b1;
    step(0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    run_instr(T_RTYPE, 1'b0, 0, 0);
    run_instr(T_LW,    1'b0, 0, 2);
    run_instr(T_BEQ,   1'b1, 0, 0);
    run_instr(T_BEQ,   1'b0, 1, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(T_SW,    1'b1, 2, 1);
    run_instr(T_ADDI,  1'b0, 0, 0);
    run_instr(T_J,     1'b1, 0, 0);

    for (int n = 0; n < 60; n++)
      run_instr(rand_op(1'b1), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));

    // sw stalled in MEMWR, then an asynchronous reset between clock edges
    op = T_SW;
    zero = 1'b0;
    step(1, 1'b1);
    step(2, 1'b0);
    step(3, 1'b0);
    step(6, 1'b0);
    step(6, 1'b0);
    do_reset();

    // climb to all-ones, then a jump must wrap the counter to 0
    for (int n = 0; n < 20 && model_cnt != (1 << CW) - 1; n++)
      run_instr(rand_op(1'b0), 1'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
    run_instr(T_J, 1'b0, 0, 0);
    step(1, 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
